alu_div_32: RTL and testbench

Sequential 32-bit signed divider for the datapath ALU. It implements the DIV operation as the inverse of the ALU adder, using restoring division: one trial subtraction per cycle. Operands are captured on a start strobe. The quotient is returned on `lo` and the remainder on `hi`, ready for the HI/LO registers. It runs beside the combinational add/sub path and is sequenced by the control unit through a start/done handshake.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_sub_33.sv | 24 ++
 rtl/alu_div_32.sv | 111 +++++++++++
 tb/tb_alu_div_32.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: widths, divider FSM states and a two's-complement negate helper.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 32;
  localparam int unsigned DIV_ITERS = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    SIGN
  } div_state_e;

  function automatic logic [ALU_WIDTH-1:0] twos_neg(input logic [ALU_WIDTH-1:0] x);
    return ~x + ALU_WIDTH'(1);
  endfunction

  function automatic logic [ALU_WIDTH-1:0] twos_abs(input logic [ALU_WIDTH-1:0] x);
    return x[ALU_WIDTH-1] ? twos_neg(x) : x;
  endfunction

endpackage

// File: rtl/alu_sub_33.sv
// 33-bit trial subtractor a - b, built as a ripple of full-adder cells computing a + ~b + 1.
module alu_sub_33
  import alu_pkg::*;
(
  input  logic [ALU_WIDTH:0] a,
  input  logic [ALU_WIDTH:0] b,
  output logic [ALU_WIDTH:0] diff,
  output logic               borrow
);

  logic [ALU_WIDTH+1:0] c;

  assign c[0] = 1'b1;

  for (genvar i = 0; i <= ALU_WIDTH; i++) begin : g_fa
    logic bn;
    assign bn       = ~b[i];
    assign diff[i]  = a[i] ^ bn ^ c[i];
    assign c[i+1]   = (a[i] & bn) | (c[i] & (a[i] ^ bn));
  end

  assign borrow = ~c[ALU_WIDTH+1];

endmodule

// File: rtl/alu_div_32.sv
// Sequential 32-bit signed restoring divider: quotient on lo, remainder on hi,
// start/done handshake, one trial subtraction per cycle.
module alu_div_32
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] Ra,
  input  logic [WIDTH-1:0] Rb,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  div_state_e       state, state_nx;
  logic [WIDTH-1:0] q, d, r;
  logic [5:0]       cnt;
  logic             sa, sb, zpend;
  logic [WIDTH:0]   rs, t;
  logic             borrow, take;

  // r[32] of the partial remainder is always zero once a trial is kept, so only 32 bits are held.
  assign rs = {r, q[WIDTH-1]};

  alu_sub_33 u_sub (
    .a      (rs),
    .b      ({1'b0, d}),
    .diff   (t),
    .borrow (borrow)
  );

  // Borrow and t[32] agree while r < d holds; either one marks a failed trial.
  assign take = ~(t[WIDTH] | borrow);
  assign busy = (state != IDLE);

  always_ff @(posedge clock or posedge clear) begin
    if (clear) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start && (Rb != '0)) state_nx = RUN;
      RUN:     if (cnt == 6'(DIV_ITERS - 1)) state_nx = SIGN;
      SIGN:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // A divide by zero parks Ra in q and reports it one edge later without leaving IDLE.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      q           <= '0;
      d           <= '0;
      r           <= '0;
      cnt         <= '0;
      sa          <= 1'b0;
      sb          <= 1'b0;
      zpend       <= 1'b0;
      lo          <= '0;
      hi          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done  <= 1'b0;
      zpend <= 1'b0;
      if (zpend) begin
        lo          <= '1;
        hi          <= q;
        div_by_zero <= 1'b1;
        done        <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            if (Rb == '0) begin
              zpend <= 1'b1;
              q     <= Ra;
            end else begin
              q           <= twos_abs(Ra);
              d           <= twos_abs(Rb);
              r           <= '0;
              cnt         <= '0;
              sa          <= Ra[WIDTH-1];
              sb          <= Rb[WIDTH-1];
              div_by_zero <= 1'b0;
            end
          end
        end
        RUN: begin
          r   <= take ? t[WIDTH-1:0] : rs[WIDTH-1:0];
          q   <= {q[WIDTH-2:0], take};
          cnt <= cnt + 6'd1;
        end
        SIGN: begin
          lo   <= (sa ^ sb) ? twos_neg(q) : q;
          hi   <= sa ? twos_neg(r) : r;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_div_32.sv
// Directed self-checking bench for alu_div_32 with hand-computed quotients and remainders.
module tb_alu_div_32;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        start = 1'b0;
  logic [31:0] Ra = '0;
  logic [31:0] Rb = '0;
  logic [31:0] lo, hi;
  logic        busy, done, div_by_zero;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  alu_div_32 #(.WIDTH(32)) dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .Ra          (Ra),
    .Rb          (Rb),
    .lo          (lo),
    .hi          (hi),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  task automatic pulse_start(input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    Ra    = a;
    Rb    = b;
    @(posedge clock);
    #1;
    start = 1'b0;
    Ra    = 32'h5A5A5A5A;
    Rb    = 32'h0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(posedge clock);
      #1;
      cyc++;
    end while (!done && cyc < 100);
  endtask

  task automatic test_reset();
    @(posedge clock);
    #1;
    total++; if (lo !== 32'h0)        begin bad++; $display("FAIL reset_lo got=%h exp=%h", lo, 32'h0); end
    total++; if (hi !== 32'h0)        begin bad++; $display("FAIL reset_hi got=%h exp=%h", hi, 32'h0); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0)       begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
    clear = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_basic();
    int cyc, busyn;
    pulse_start(32'd100, 32'd7);
    busyn = busy ? 1 : 0;
    cyc   = 0;
    do begin
      @(posedge clock);
      #1;
      cyc++;
      if (busy) busyn++;
    end while (!done && cyc < 100);
    total++; if (cyc !== 33)           begin bad++; $display("FAIL basic_latency got=%0d exp=33", cyc); end
    total++; if (busyn !== 33)         begin bad++; $display("FAIL basic_busy_cycles got=%0d exp=33", busyn); end
    total++; if (lo !== 32'd14)        begin bad++; $display("FAIL basic_lo got=%h exp=%h", lo, 32'd14); end
    total++; if (hi !== 32'd2)         begin bad++; $display("FAIL basic_hi got=%h exp=%h", hi, 32'd2); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL basic_dbz got=%b exp=0", div_by_zero); end
    @(posedge clock);
    #1;
    total++; if (done !== 1'b0)        begin bad++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
    total++; if (lo !== 32'd14)        begin bad++; $display("FAIL basic_lo_hold got=%h exp=%h", lo, 32'd14); end
  endtask

  task automatic test_signs();
    int cyc;
    pulse_start(32'hFFFFFFF9, 32'd2);
    wait_done(cyc);
    total++; if (cyc !== 33)           begin bad++; $display("FAIL neg_dividend_latency got=%0d exp=33", cyc); end
    total++; if (lo !== 32'hFFFFFFFD)  begin bad++; $display("FAIL neg_dividend_lo got=%h exp=%h", lo, 32'hFFFFFFFD); end
    total++; if (hi !== 32'hFFFFFFFF)  begin bad++; $display("FAIL neg_dividend_hi got=%h exp=%h", hi, 32'hFFFFFFFF); end
    pulse_start(32'd7, 32'hFFFFFFFE);
    wait_done(cyc);
    total++; if (lo !== 32'hFFFFFFFD)  begin bad++; $display("FAIL neg_divisor_lo got=%h exp=%h", lo, 32'hFFFFFFFD); end
    total++; if (hi !== 32'd1)         begin bad++; $display("FAIL neg_divisor_hi got=%h exp=%h", hi, 32'd1); end
  endtask

  task automatic test_clear_abort();
    int cyc;
    bit seen;
    pulse_start(32'd100, 32'd7);
    repeat (10) @(posedge clock);
    #3;
    clear = 1'b1;
    #1;
    total++; if (lo !== 32'h0)         begin bad++; $display("FAIL clear_lo got=%h exp=%h", lo, 32'h0); end
    total++; if (hi !== 32'h0)         begin bad++; $display("FAIL clear_hi got=%h exp=%h", hi, 32'h0); end
    total++; if (busy !== 1'b0)        begin bad++; $display("FAIL clear_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0)        begin bad++; $display("FAIL clear_done got=%b exp=0", done); end
    @(negedge clock);
    clear = 1'b0;
    seen  = 1'b0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (done) seen = 1'b1;
    end
    total++; if (seen !== 1'b0)        begin bad++; $display("FAIL clear_no_done got=%b exp=0", seen); end
    total++; if (busy !== 1'b0)        begin bad++; $display("FAIL clear_idle_busy got=%b exp=0", busy); end
    pulse_start(32'd9, 32'd3);
    wait_done(cyc);
    total++; if (cyc !== 33)           begin bad++; $display("FAIL after_clear_latency got=%0d exp=33", cyc); end
    total++; if (lo !== 32'd3)         begin bad++; $display("FAIL after_clear_lo got=%h exp=%h", lo, 32'd3); end
    total++; if (hi !== 32'd0)         begin bad++; $display("FAIL after_clear_hi got=%h exp=%h", hi, 32'd0); end
  endtask

  task automatic test_div_zero();
    pulse_start(32'd7, 32'd0);
    total++; if (busy !== 1'b0)        begin bad++; $display("FAIL dz_busy_e0 got=%b exp=0", busy); end
    total++; if (done !== 1'b0)        begin bad++; $display("FAIL dz_done_e0 got=%b exp=0", done); end
    @(posedge clock);
    #1;
    total++; if (done !== 1'b1)        begin bad++; $display("FAIL dz_done got=%b exp=1", done); end
    total++; if (lo !== 32'hFFFFFFFF)  begin bad++; $display("FAIL dz_lo got=%h exp=%h", lo, 32'hFFFFFFFF); end
    total++; if (hi !== 32'd7)         begin bad++; $display("FAIL dz_hi got=%h exp=%h", hi, 32'd7); end
    total++; if (div_by_zero !== 1'b1) begin bad++; $display("FAIL dz_flag got=%b exp=1", div_by_zero); end
    total++; if (busy !== 1'b0)        begin bad++; $display("FAIL dz_busy_e1 got=%b exp=0", busy); end
    @(posedge clock);
    #1;
    total++; if (done !== 1'b0)        begin bad++; $display("FAIL dz_done_pulse got=%b exp=0", done); end
    total++; if (div_by_zero !== 1'b1) begin bad++; $display("FAIL dz_flag_hold got=%b exp=1", div_by_zero); end
  endtask

  task automatic test_boundary();
    int cyc;
    pulse_start(32'h80000000, 32'hFFFFFFFF);
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL wrap_dbz_cleared got=%b exp=0", div_by_zero); end
    wait_done(cyc);
    total++; if (lo !== 32'h80000000)  begin bad++; $display("FAIL wrap_lo got=%h exp=%h", lo, 32'h80000000); end
    total++; if (hi !== 32'h0)         begin bad++; $display("FAIL wrap_hi got=%h exp=%h", hi, 32'h0); end
    pulse_start(32'd0, 32'd5);
    wait_done(cyc);
    total++; if (lo !== 32'h0)         begin bad++; $display("FAIL zero_lo got=%h exp=%h", lo, 32'h0); end
    total++; if (hi !== 32'h0)         begin bad++; $display("FAIL zero_hi got=%h exp=%h", hi, 32'h0); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    pulse_start(32'd100, 32'd7);
    repeat (4) @(posedge clock);
    #1;
    start = 1'b1;
    Ra    = 32'd50;
    Rb    = 32'd5;
    @(posedge clock);
    #1;
    start = 1'b0;
    wait_done(cyc);
    total++; if (cyc !== 28)           begin bad++; $display("FAIL ignore_start_latency got=%0d exp=28", cyc); end
    total++; if (lo !== 32'd14)        begin bad++; $display("FAIL ignore_start_lo got=%h exp=%h", lo, 32'd14); end
    total++; if (hi !== 32'd2)         begin bad++; $display("FAIL ignore_start_hi got=%h exp=%h", hi, 32'd2); end
    start = 1'b1;
    Ra    = 32'd50;
    Rb    = 32'd5;
    @(posedge clock);
    #1;
    start = 1'b0;
    total++; if (busy !== 1'b1)        begin bad++; $display("FAIL b2b_accept_busy got=%b exp=1", busy); end
    total++; if (lo !== 32'd14)        begin bad++; $display("FAIL b2b_lo_hold got=%h exp=%h", lo, 32'd14); end
    wait_done(cyc);
    total++; if (cyc + 1 !== 34)       begin bad++; $display("FAIL b2b_spacing got=%0d exp=34", cyc + 1); end
    total++; if (lo !== 32'd10)        begin bad++; $display("FAIL b2b_lo got=%h exp=%h", lo, 32'd10); end
    total++; if (hi !== 32'd0)         begin bad++; $display("FAIL b2b_hi got=%h exp=%h", hi, 32'd0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_clear_abort();
    test_div_zero();
    test_boundary();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
